// File: rtl/evm_tally_uart_tx_pkg.sv
// Shared constants for the EVM tally readout link: frame header, selector
// encodings and sequencer state codes.
package evm_tally_uart_tx_pkg;

  localparam logic [7:0] HDR_BYTE  = 8'hA5;
  localparam int         FRAME_LEN = 6;

  // display_results selector encodings
  localparam logic [1:0] SEL_IDLE = 2'b00;
  localparam logic [1:0] SEL_C1   = 2'b01;
  localparam logic [1:0] SEL_C2   = 2'b10;
  localparam logic [1:0] SEL_C3   = 2'b11;

  // Sequencer states; SEND_LAST waits for the final stop bit to finish
  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE      = 3'd0;
  localparam state_t ST_SLOT      = 3'd1;
  localparam state_t ST_SEND      = 3'd2;
  localparam state_t ST_SEND_LAST = 3'd3;
  localparam state_t ST_FIN       = 3'd4;

  // Selector value presented during capture slot k (slot 3 is the winner slot)
  function automatic logic [1:0] sel_for_slot(input logic [1:0] slot);
    case (slot)
      2'd0:    sel_for_slot = SEL_C1;
      2'd1:    sel_for_slot = SEL_C2;
      2'd2:    sel_for_slot = SEL_C3;
      default: sel_for_slot = SEL_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/evm_tally_uart_tx_if.sv
// Bundle of the EVM-side and UART-side signals of the tally readout block.
// The reader block is the slave; the EVM wrapper / bench is the master.
interface evm_tally_uart_tx_if #(
  parameter int RES_W = 7
);
  logic             start;
  logic             voting_done;
  logic [1:0]       sel_out;
  logic             winner_req;
  logic [RES_W-1:0] results_in;
  logic [1:0]       winner_in;
  logic             invalid_in;
  logic             tx;
  logic             busy;
  logic             done;
  logic             err;

  modport master (
    output start, voting_done, results_in, winner_in, invalid_in,
    input  sel_out, winner_req, tx, busy, done, err
  );

  modport slave (
    input  start, voting_done, results_in, winner_in, invalid_in,
    output sel_out, winner_req, tx, busy, done, err
  );
endinterface

// File: rtl/evm_tally_uart_tx_uart_tx_byte.sv
// 8N1 byte serializer with valid/ready handshake. Ready rises in the last
// cycle of the stop bit so consecutive bytes leave with no idle gap.
module uart_tx_byte #(
  parameter int CLKS_PER_BIT = 87
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_valid,
  input  logic [7:0] i_data,
  output logic       o_ready,
  output logic       o_tx
);
  localparam int BAUD_W = $clog2(CLKS_PER_BIT + 1);

  logic              r_active;
  logic [3:0]        r_bit;     // 0 start, 1..8 data, 9 stop
  logic [BAUD_W-1:0] r_baud;
  logic [7:0]        r_shift;
  logic              r_tx;
  logic              w_bit_end;
  logic              w_stop_end;

  assign w_bit_end  = (r_baud == BAUD_W'(CLKS_PER_BIT - 1));
  assign w_stop_end = r_active && (r_bit == 4'd9) && w_bit_end;
  assign o_ready    = !r_active || w_stop_end;
  assign o_tx       = r_tx;

  // Bit timing: load on handshake, shift LSB-first at each bit boundary
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_active <= 1'b0;
      r_bit    <= 4'd0;
      r_baud   <= '0;
      r_shift  <= 8'h00;
      r_tx     <= 1'b1;
    end else if (i_valid && o_ready) begin
      r_active <= 1'b1;
      r_bit    <= 4'd0;
      r_baud   <= '0;
      r_shift  <= i_data;
      r_tx     <= 1'b0;
    end else if (w_stop_end) begin
      r_active <= 1'b0;
      r_bit    <= 4'd0;
      r_baud   <= '0;
      r_tx     <= 1'b1;
    end else if (r_active) begin
      if (w_bit_end) begin
        r_baud <= '0;
        r_bit  <= r_bit + 4'd1;
        if (r_bit < 4'd8) begin
          r_tx    <= r_shift[0];
          r_shift <= {1'b0, r_shift[7:1]};
        end else begin
          r_tx <= 1'b1;
        end
      end else begin
        r_baud <= r_baud + BAUD_W'(1);
      end
    end else begin
      r_tx <= 1'b1;
    end
  end

endmodule

// File: rtl/evm_tally_uart_tx.sv
// EVM results reader: walks the display_results selector through the three
// candidates and the winner slot, buffers what it captures, then sends
// header, four buffer bytes and an XOR checksum over the UART line.
module evm_tally_uart_tx
  import evm_tally_uart_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 87,
  parameter int SETTLE       = 2,
  parameter int RES_W        = 7
) (
  input logic              clk,
  input logic              rst_n,
  evm_tally_uart_tx_if.slave bus
);
  localparam int CNT_W = $clog2(SETTLE + 1);

  state_t           r_state;
  logic [1:0]       r_slot;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_byte_idx;
  logic [7:0]       r_buf [4];
  logic [7:0]       r_chk;
  logic             r_valid;
  logic [1:0]       r_sel;
  logic             r_winner_req;
  logic             r_busy;
  logic             r_done;
  logic             r_err;

  logic [RES_W-1:0] w_res;
  logic [7:0]       w_cap;
  logic [7:0]       w_byte;
  logic             w_ready;
  logic             w_tx;

  assign w_res = bus.results_in;

  // Value captured at the end of the current slot
  always_comb begin
    w_cap = 8'h00;
    if (r_slot == 2'd3) begin
      w_cap = {bus.invalid_in, 5'b00000, bus.winner_in};
    end else begin
      w_cap = 8'(w_res);
    end
  end

  // Frame byte presented to the serializer
  always_comb begin
    w_byte = HDR_BYTE;
    case (r_byte_idx)
      3'd0:    w_byte = HDR_BYTE;
      3'd1:    w_byte = r_buf[0];
      3'd2:    w_byte = r_buf[1];
      3'd3:    w_byte = r_buf[2];
      3'd4:    w_byte = r_buf[3];
      3'd5:    w_byte = r_chk;
      default: w_byte = HDR_BYTE;
    endcase
  end

  // Slot/byte sequencer, capture buffer and running checksum
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_slot       <= 2'd0;
      r_cnt        <= '0;
      r_byte_idx   <= 3'd0;
      for (int i = 0; i < 4; i++) r_buf[i] <= 8'h00;
      r_chk        <= 8'h00;
      r_valid      <= 1'b0;
      r_sel        <= SEL_IDLE;
      r_winner_req <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.start && bus.voting_done) begin
            r_state      <= ST_SLOT;
            r_slot       <= 2'd0;
            r_cnt        <= '0;
            r_sel        <= sel_for_slot(2'd0);
            r_winner_req <= 1'b0;
            r_busy       <= 1'b1;
            r_chk        <= HDR_BYTE;
          end else if (bus.start) begin
            r_err <= 1'b1;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_SLOT: begin
          if (r_cnt == CNT_W'(SETTLE)) begin
            r_cnt         <= '0;
            r_buf[r_slot] <= w_cap;
            r_chk         <= r_chk ^ w_cap;
            if (r_slot == 2'd3) begin
              r_state      <= ST_SEND;
              r_sel        <= SEL_IDLE;
              r_winner_req <= 1'b0;
              r_byte_idx   <= 3'd0;
              r_valid      <= 1'b1;
            end else begin
              r_slot       <= r_slot + 2'd1;
              r_sel        <= sel_for_slot(r_slot + 2'd1);
              r_winner_req <= (r_slot == 2'd2);
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        ST_SEND: begin
          if (r_valid && w_ready) begin
            if (r_byte_idx == 3'(FRAME_LEN - 1)) begin
              r_valid <= 1'b0;
              r_state <= ST_SEND_LAST;
            end else begin
              r_byte_idx <= r_byte_idx + 3'd1;
            end
          end else begin
            r_state <= ST_SEND;
          end
        end
        ST_SEND_LAST: begin
          if (w_ready) begin
            r_state <= ST_FIN;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
          end else begin
            r_state <= ST_SEND_LAST;
          end
        end
        ST_FIN: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_uart_tx_byte (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_valid(r_valid),
    .i_data (w_byte),
    .o_ready(w_ready),
    .o_tx   (w_tx)
  );

  assign bus.sel_out    = r_sel;
  assign bus.winner_req = r_winner_req;
  assign bus.tx         = w_tx;
  assign bus.busy       = r_busy;
  assign bus.done       = r_done;
  assign bus.err        = r_err;

endmodule
